// File: rtl/omr_pkg.sv
// Shared constants, answer-code types and the negative-marking clamp
// used by the OMR grading block.
package omr_pkg;

    localparam int NUM_Q   = 10;
    localparam int ANS_W   = 4;
    localparam int SCORE_W = 4;

    // One extra bit holds 2*C without wrapping, because 2^SCORE_W > NUM_Q.
    localparam int CLAMP_W = SCORE_W + 1;

    typedef logic [ANS_W-1:0]       ans_code_t;
    typedef logic [NUM_Q*ANS_W-1:0] ans_sheet_t;
    typedef logic [SCORE_W-1:0]     score_t;

    // max(0, 2C - NUM_Q): +1 per correct answer, -1 per wrong answer, floored at zero.
    function automatic score_t neg_mark(input score_t correct_cnt);
        logic [CLAMP_W-1:0] twice;
        logic [CLAMP_W-1:0] diff;
        twice = {correct_cnt, 1'b0};
        diff  = twice - CLAMP_W'(NUM_Q);
        if (twice > CLAMP_W'(NUM_Q)) begin
            neg_mark = diff[SCORE_W-1:0];
        end else begin
            neg_mark = '0;
        end
    endfunction

endpackage

// File: rtl/omr_machine_if.sv
// Sheet/key input bundle and registered score outputs of the grader.
// in_valid is a push-only strobe: every cycle it is high the grader
// consumes the sheet at that edge; there is no ready and no backpressure.
interface omr_machine_if;
    import omr_pkg::*;

    logic       in_valid;
    ans_sheet_t correct_answers;
    ans_sheet_t student_answers;
    score_t     score1;
    score_t     score;
    logic       out_valid;

    modport master (
        output in_valid,
        output correct_answers,
        output student_answers,
        input  score1,
        input  score,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  correct_answers,
        input  student_answers,
        output score1,
        output score,
        output out_valid
    );

endinterface

// File: rtl/omr_answer_compare.sv
// Single-question comparator: an answer is correct only on an exact code match,
// so a blank (all-zero) response scores only against an all-zero key.
module omr_answer_compare
    import omr_pkg::*;
(
    input  ans_code_t i_key,
    input  ans_code_t i_student,
    output logic      o_match
);

    assign o_match = (i_key == i_student);

endmodule

// File: rtl/omr_machine.sv
// OMR sheet grader: per-question compare, popcount and negative-marking clamp
// feed one register stage, so results appear one cycle after in_valid.
module omr_machine
    import omr_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    omr_machine_if.slave  bus
);

    logic [NUM_Q-1:0] w_match;
    score_t           w_correct_cnt;
    score_t           w_neg_score;

    score_t           r_score1;
    score_t           r_score;
    logic             r_out_valid;

    for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_cmp
        omr_answer_compare u_cmp (
            .i_key     (bus.correct_answers[ANS_W*gi +: ANS_W]),
            .i_student (bus.student_answers[ANS_W*gi +: ANS_W]),
            .o_match   (w_match[gi])
        );
    end

    always_comb begin
        w_correct_cnt = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            w_correct_cnt = w_correct_cnt + SCORE_W'(w_match[i]);
        end
    end

    assign w_neg_score = neg_mark(w_correct_cnt);

    // Reset wins over in_valid, discarding any grade presented on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_score1    <= '0;
            r_score     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_score1 <= w_correct_cnt;
                r_score  <= w_neg_score;
            end
        end
    end

    assign bus.score1    = r_score1;
    assign bus.score     = r_score;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_omr_machine.sv
// Directed bench for omr_machine: reset, exact-match grading, clamp boundary,
// hold, back-to-back sheets and reset during a capture.
module tb_omr_machine;
    import omr_pkg::*;

    localparam ans_sheet_t KEY = 40'h123456789A;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // {score1, score} pairs expected on consecutive cycles
    logic [2*SCORE_W-1:0] exp_q[$];

    omr_machine_if bus ();

    omr_machine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive_idle();
        bus.in_valid        = 1'b0;
        bus.correct_answers = '0;
        bus.student_answers = '0;
    endtask

    // Presents one sheet for one edge; on return outputs reflect that sheet.
    task automatic apply_sheet(input ans_sheet_t key, input ans_sheet_t stu);
        @(negedge clk);
        bus.in_valid        = 1'b1;
        bus.correct_answers = key;
        bus.student_answers = stu;
        @(negedge clk);
        bus.in_valid        = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset               = 1'b1;
        bus.in_valid        = 1'b1;
        bus.correct_answers = {$urandom(), $urandom_range(255, 0)};
        bus.student_answers = bus.correct_answers;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.score1 !== 4'd0 || bus.score !== 4'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got score1=%0d score=%0d out_valid=%b, want 0/0/0",
                     bus.score1, bus.score, bus.out_valid);
        end
        reset = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.score1 !== 4'd0 || bus.score !== 4'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got score1=%0d score=%0d out_valid=%b, want 0/0/0",
                     bus.score1, bus.score, bus.out_valid);
        end
    endtask

    task automatic test_grading();
        ans_sheet_t keys   [8];
        ans_sheet_t stus   [8];
        score_t     exp_s1 [8];
        score_t     exp_s  [8];
        keys[0] = KEY;   stus[0] = 40'h123456789A; exp_s1[0] = 4'd10; exp_s[0] = 4'd10;
        keys[1] = KEY;   stus[1] = 40'h123406709A; exp_s1[1] = 4'd8;  exp_s[1] = 4'd6;
        keys[2] = KEY;   stus[2] = 40'h123456709A; exp_s1[2] = 4'd9;  exp_s[2] = 4'd8;
        keys[3] = KEY;   stus[3] = 40'h8421564212; exp_s1[3] = 4'd2;  exp_s[3] = 4'd0;
        keys[4] = KEY;   stus[4] = 40'h0;          exp_s1[4] = 4'd0;  exp_s[4] = 4'd0;
        keys[5] = KEY;   stus[5] = 40'h1234500000; exp_s1[5] = 4'd5;  exp_s[5] = 4'd0;
        keys[6] = KEY;   stus[6] = 40'h1234560000; exp_s1[6] = 4'd6;  exp_s[6] = 4'd2;
        keys[7] = 40'h0; stus[7] = 40'h0;          exp_s1[7] = 4'd10; exp_s[7] = 4'd10;
        for (int i = 0; i < 8; i++) begin
            apply_sheet(keys[i], stus[i]);
            checks++;
            if (bus.score1 !== exp_s1[i] || bus.score !== exp_s[i] || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL grade[%0d]: got score1=%0d score=%0d out_valid=%b, want %0d/%0d/1",
                         i, bus.score1, bus.score, bus.out_valid, exp_s1[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2*SCORE_W-1:0] exp;
        exp_q.push_back({4'd10, 4'd10});
        exp_q.push_back({4'd9, 4'd8});
        @(negedge clk);
        bus.in_valid        = 1'b1;
        bus.correct_answers = KEY;
        bus.student_answers = KEY;
        @(negedge clk);
        bus.student_answers = 40'h123456709A;
        for (int i = 0; i < 2; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if ({bus.score1, bus.score} !== exp || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d]: got score1=%0d score=%0d out_valid=%b, want %0d/%0d/1",
                         i, bus.score1, bus.score, bus.out_valid,
                         exp[2*SCORE_W-1:SCORE_W], exp[SCORE_W-1:0]);
            end
            if (i == 0) begin
                @(negedge clk);
                bus.in_valid        = 1'b0;
                bus.student_answers = 40'h0;
            end
        end
        @(negedge clk);
        checks++;
        if (bus.score1 !== 4'd9 || bus.score !== 4'd8 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold: got score1=%0d score=%0d out_valid=%b, want 9/8/0",
                     bus.score1, bus.score, bus.out_valid);
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        reset               = 1'b1;
        bus.in_valid        = 1'b1;
        bus.correct_answers = KEY;
        bus.student_answers = KEY;
        @(negedge clk);
        checks++;
        if (bus.score1 !== 4'd0 || bus.score !== 4'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop: got score1=%0d score=%0d out_valid=%b, want 0/0/0",
                     bus.score1, bus.score, bus.out_valid);
        end
        reset = 1'b0;
        drive_idle();
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive_idle();
        test_reset();
        test_grading();
        test_back_to_back();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
